mips_muldiv_unit: RTL and testbench
===================================

MIPS_MULDIV_UNIT -- requirements
Module: mips_muldiv_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand, HI and LO width; SHALL be even and >= 8.
REQ-002 Parameter SIGNED_EN, default 1: 1 enables the signed MULT/DIV ops; 0 executes signed ops as their unsigned forms.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request strobe; sampled only when busy=0.
REQ-006 op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-007 data_in1  input  DATA_WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO source.
REQ-008 data_in2  input  DATA_WIDTH  rt operand: multiplier or divisor.
REQ-009 flush  input  1  cancels an in-flight op.
REQ-010 busy  output  1  multi-cycle op in progress.
REQ-011 done  output  1  one-cycle pulse; HI/LO updated by a MULT/DIV op.
REQ-012 div_zero  output  1  sticky flag: the last completed DIV/DIVU had divisor 0.
REQ-013 hi, lo  output  DATA_WIDTH each  HI/LO architectural registers.

Function
REQ-014 FSM states: IDLE, RUN, FIX. Only IDLE accepts start.
REQ-015 IDLE + start + op in {MULT, MULTU, DIV, DIVU} -> RUN at edge E0. Operands are latched as magnitudes; result signs are recorded (signed ops only); the iteration counter is loaded with DATA_WIDTH.
REQ-016 RUN: one iteration per cycle. Multiply is radix-2 shift-add. Divide is restoring, 1 quotient bit per cycle. After DATA_WIDTH iterations (edge E_W) -> FIX.
REQ-017 FIX (edge E_W+1): sign correction; hi/lo written; done=1 for exactly that following cycle; -> IDLE. Total latency start-to-done is DATA_WIDTH+1 cycles.
REQ-018 busy=1 from after E0 until after E_W+1; busy=0 in the done cycle, so a new start is accepted in the done cycle.
REQ-019 Multiply: {hi,lo} = full 2*DATA_WIDTH-bit product, two's complement for MULT, unsigned for MULTU.
REQ-020 Divide: lo = quotient truncated toward zero; hi = remainder carrying the dividend's sign.
REQ-021 Divisor 0: lo = all ones, hi = data_in1, div_zero set to 1, normal latency. div_zero is cleared by the next completed DIV/DIVU with a nonzero divisor.
REQ-022 Signed overflow (MIN / -1): lo = MIN, hi = 0, no flag.
REQ-023 MTHI/MTLO with start in IDLE: hi (or lo) <= data_in1 at the next edge, with no busy and no done.
REQ-024 Reserved op codes are ignored: no state change.
REQ-025 start while busy=1 is ignored; there is no queuing.
REQ-026 flush in RUN or FIX -> IDLE at the next edge; hi, lo and div_zero unchanged; no done. flush in IDLE has no effect. flush together with start in IDLE: flush wins and the op is dropped.
REQ-027 Operand inputs need only be valid in the start cycle; later changes SHALL NOT affect the result.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, busy=0, done=0, div_zero=0, hi=0, lo=0, regardless of clk.
REQ-029 Reset mid-RUN or mid-FIX abandons the op; no done after release.
REQ-030 After rst_n rises, start is accepted from the first rising edge.

Verification (DATA_WIDTH=32)
REQ-031 MULT 0xFFFFFFFE x 0x00000003 -> done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-032 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 DIVU 5 / 0 -> lo=0xFFFFFFFF, hi=5, div_zero=1. Then DIVU 9 / 3 -> lo=3, hi=0, div_zero=0.
REQ-035 MULTU started, flush pulsed at cycle 10 -> busy=0 next cycle; no done; hi/lo keep prior values. A start issued during busy produces no second done.
REQ-036 rst_n pulsed low mid-DIV between clock edges -> outputs zero immediately; no done. MTLO 0x1234 then MTHI 0x5678 -> lo=0x1234, hi=0x5678, busy never set.

Source files
------------

// File: rtl/mips_muldiv_unit.sv
// Purpose: MIPS HI/LO multiply/divide unit (MULT/MULTU/DIV/DIVU, MTHI/MTLO).
// Latency: DATA_WIDTH+1 cycles start-to-done for mul/div; MTHI/MTLO write at the next edge.
// Backpressure: start is only taken while busy=0; requests during busy are dropped, not queued.
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter bit SIGNED_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] data_in1,
  input  logic [DATA_WIDTH-1:0] data_in2,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic                  div_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W  = DATA_WIDTH;
  localparam int W2 = 2 * DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t          state_q, state_d;
  logic [W:0]      acc_q, acc_d;     // product high half / partial remainder
  logic [W-1:0]    low_q, low_d;     // multiplier shifting out / dividend in, quotient out
  logic [W-1:0]    b_q;              // multiplicand or divisor magnitude
  logic [CW-1:0]   cnt_q;
  logic            is_div_q, b_zero_q, res_neg_q, rem_neg_q;
  logic            done_q, dz_q;
  logic [W-1:0]    hi_q, lo_q;

  // Request decode: flush in IDLE suppresses any start in the same cycle
  logic            md_req, mv_req, sgn_op, neg1, neg2;
  logic [W-1:0]    mag1, mag2;

  assign md_req = (state_q == S_IDLE) && start && !flush && !op[2];
  assign mv_req = (state_q == S_IDLE) && start && !flush && (op == OP_MTHI || op == OP_MTLO);
  assign sgn_op = SIGNED_EN && !op[0];
  assign neg1   = sgn_op & data_in1[W-1];
  assign neg2   = sgn_op & data_in2[W-1];
  assign mag1   = neg1 ? (~data_in1 + W'(1)) : data_in1;
  assign mag2   = neg2 ? (~data_in2 + W'(1)) : data_in2;

  // One iteration: radix-2 shift-add multiply or restoring divide step
  logic [W:0] mul_sum, div_t, div_diff;
  logic       div_ge;
  always_comb begin
    mul_sum  = acc_q + {1'b0, b_q & {W{low_q[0]}}};
    div_t    = {acc_q[W-1:0], low_q[W-1]};
    div_ge   = (div_t >= {1'b0, b_q});
    div_diff = div_t - {1'b0, b_q};
    if (is_div_q) begin
      acc_d = div_ge ? div_diff : div_t;
      low_d = {low_q[W-2:0], div_ge};
    end else begin
      acc_d = {1'b0, mul_sum[W:1]};
      low_d = {mul_sum[0], low_q[W-1:1]};
    end
  end

  // Sign correction of the magnitude result; divide-by-zero forces an all-ones quotient
  logic [W2-1:0] prod, prod_c;
  logic [W-1:0]  quo_c, rem_c, hi_res, lo_res;
  always_comb begin
    prod   = {acc_q[W-1:0], low_q};
    prod_c = res_neg_q ? (~prod + W2'(1)) : prod;
    quo_c  = res_neg_q ? (~low_q + W'(1)) : low_q;
    rem_c  = rem_neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    if (is_div_q) begin
      hi_res = rem_c;
      lo_res = b_zero_q ? '1 : quo_c;
    end else begin
      {hi_res, lo_res} = prod_c;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: count W iterations in RUN, one fix-up cycle, flush aborts
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (md_req) state_d = S_RUN;
      S_RUN:   if (flush) state_d = S_IDLE;
               else if (cnt_q == CW'(1)) state_d = S_FIX;
      S_FIX:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = done_q;
    div_zero = dz_q;
    hi       = hi_q;
    lo       = lo_q;
  end

  // Datapath: operand capture, iteration, architectural HI/LO and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      low_q     <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (md_req) begin
        acc_q     <= '0;
        low_q     <= mag1;
        b_q       <= mag2;
        cnt_q     <= CW'(W);
        is_div_q  <= op[1];
        b_zero_q  <= (data_in2 == '0);
        res_neg_q <= neg1 ^ neg2;
        rem_neg_q <= neg1;
      end
      if (mv_req && !op[0]) hi_q <= data_in1;
      if (mv_req &&  op[0]) lo_q <= data_in1;
      if (state_q == S_RUN && !flush) begin
        acc_q <= acc_d;
        low_q <= low_d;
        cnt_q <= cnt_q - CW'(1);
      end
      if (state_q == S_FIX && !flush) begin
        hi_q   <= hi_res;
        lo_q   <= lo_res;
        done_q <= 1'b1;
        if (is_div_q) dz_q <= b_zero_q;
      end
    end
  end

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Bench for mips_muldiv_unit at DATA_WIDTH=32: directed vectors, a latency/arithmetic
// reference model compared every cycle, and literal expectations for key results.
module tb_mips_muldiv_unit;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op = 3'b000;
  logic [W-1:0]  data_in1 = '0;
  logic [W-1:0]  data_in2 = '0;
  logic          busy, done, div_zero;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mips_muldiv_unit #(.DATA_WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .data_in1(data_in1), .data_in2(data_in2), .flush(flush),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Architectural result of one mul/div op, straight from integer arithmetic
  function automatic void model_result(input logic [2:0] o, input logic [W-1:0] a, b,
                                       output logic [W-1:0] h, l, output logic dz, isd);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    isd = o[1];
    p = '0;
    case (o)
      3'd0: p = sa * sb;
      3'd1: p = {32'h0, a} * {32'h0, b};
      3'd2: if (b == 0) begin p = {a, 32'hFFFF_FFFF}; dz = 1'b1; end
            else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
      3'd3: if (b == 0) begin p = {a, 32'hFFFF_FFFF}; dz = 1'b1; end
            else p = {a % b, a / b};
      default: p = '0;
    endcase
    h = p[63:32];
    l = p[31:0];
  endfunction

  // Reference model: an accepted mul/div commits W+1 edges later unless flushed
  int          m_left = 0;
  logic [W-1:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  logic        m_dz = 1'b0, m_done = 1'b0, p_dz = 1'b0, p_isdiv = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_dz = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        if (flush) m_left = 0;
        else begin
          m_left--;
          if (m_left == 0) begin
            m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
            if (p_isdiv) m_dz = p_dz;
          end
        end
      end else if (start && !flush) begin
        if (op <= 3'd3) begin
          model_result(op, data_in1, data_in2, p_hi, p_lo, p_dz, p_isdiv);
          m_left = W + 1;
        end else if (op == 3'd4) m_hi = data_in1;
        else if (op == 3'd5) m_lo = data_in1;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk1("busy", busy, m_left > 0);
      chk1("done", done, m_done);
      chk1("div_zero", div_zero, m_dz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Drive one start at the current negedge; operands are scrambled afterwards
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, b);
    start = 1'b1; op = o; data_in1 = a; data_in2 = b;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom_range(0, 7)); data_in1 = $urandom; data_in2 = $urandom;
  endtask

  task automatic wait_done(input string nm, output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (done !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: no done within %0d cycles", nm, cyc);
    end
  endtask

  task automatic count_done(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (done === 1'b1) c++;
    end
  endtask

  int cyc, nd;

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_dz", div_zero, 1'b0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // MTLO/MTHI, accepted from the first edge after reset release
    issue(3'd5, 32'h1234, 32'h0);
    chk1("mtlo_busy", busy, 1'b0);
    issue(3'd4, 32'h5678, 32'h0);
    chk1("mthi_busy", busy, 1'b0);
    chk("mt_lo", lo, 32'h1234);
    chk("mt_hi", hi, 32'h5678);

    // Reserved op ignored; flush with start in IDLE drops the op
    issue(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk1("rsv_busy", busy, 1'b0);
    start = 1'b1; flush = 1'b1; op = 3'd4; data_in1 = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start_hi", hi, 32'h5678);
    chk1("flush_start_busy", busy, 1'b0);

    issue(3'd0, 32'hFFFF_FFFE, 32'h3);
    wait_done("mult", cyc);
    chk("mult_latency", 32'(cyc), 32'd33);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    // Started in the done cycle of the previous op
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu", cyc);
    chk("multu_latency", 32'(cyc), 32'd33);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min", cyc);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);

    issue(3'd2, 32'hFFFF_FFF9, 32'h2);
    wait_done("div_neg", cyc);
    chk("div_neg_lo", lo, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi, 32'hFFFF_FFFF);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", cyc);
    chk("div_ovf_lo", lo, 32'h8000_0000);
    chk("div_ovf_hi", hi, 32'h0);
    chk1("div_ovf_dz", div_zero, 1'b0);

    issue(3'd3, 32'h5, 32'h0);
    wait_done("divu_zero", cyc);
    chk("divu_zero_latency", 32'(cyc), 32'd33);
    chk("divu_zero_lo", lo, 32'hFFFF_FFFF);
    chk("divu_zero_hi", hi, 32'h5);
    chk1("divu_zero_dz", div_zero, 1'b1);

    issue(3'd2, 32'hFFFF_FFF0, 32'h0);
    wait_done("div_zero_neg", cyc);
    chk("div_zero_neg_lo", lo, 32'hFFFF_FFFF);
    chk("div_zero_neg_hi", hi, 32'hFFFF_FFF0);

    issue(3'd3, 32'h9, 32'h3);
    wait_done("divu", cyc);
    chk("divu_lo", lo, 32'h3);
    chk("divu_hi", hi, 32'h0);
    chk1("divu_dz", div_zero, 1'b0);

    // Flush mid-RUN
    issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk1("flush_busy", busy, 1'b0);
    chk("flush_hi", hi, 32'h0);
    chk("flush_lo", lo, 32'h3);
    count_done(40, nd);
    chk("flush_no_done", 32'(nd), 32'd0);

    // Start while busy is ignored
    issue(3'd0, 32'h3, 32'h4);
    repeat (5) @(negedge clk);
    issue(3'd1, 32'h7, 32'h7);
    count_done(60, nd);
    chk("busy_start_dones", 32'(nd), 32'd1);
    chk("busy_start_lo", lo, 32'hC);
    chk("busy_start_hi", hi, 32'h0);

    // Asynchronous reset between edges mid-DIV
    issue(3'd2, 32'd100, 32'd7);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_dz", div_zero, 1'b0);
    chk("arst_hi", hi, 32'h0);
    chk("arst_lo", lo, 32'h0);
    #1 rst_n = 1'b1;
    count_done(45, nd);
    chk("arst_no_done", 32'(nd), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
